// File: rtl/mac_mul_stage_if.sv
// Operand/product handshake bundle for the two-stage multiplier.
// The slave side is the multiplier; the master side is upstream unpack plus downstream accumulate.
interface mac_mul_stage_if #(
    parameter int unsigned width_exp  = 5,
    parameter int unsigned width_man  = 10,
    parameter int unsigned width_pexp = width_exp + 2,
    parameter int unsigned width_pman = 2*width_man + 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  a_sign;
    logic [width_exp-1:0]  a_exp;
    logic [width_man-1:0]  a_man;
    logic                  a_zero;
    logic                  b_sign;
    logic [width_exp-1:0]  b_exp;
    logic [width_man-1:0]  b_man;
    logic                  b_zero;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [width_pexp-1:0] out_exp;
    logic [width_pman-1:0] out_man;
    logic                  out_zero;

    modport master (
        output in_valid, a_sign, a_exp, a_man, a_zero,
               b_sign, b_exp, b_man, b_zero, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_zero
    );

    modport slave (
        input  in_valid, a_sign, a_exp, a_man, a_zero,
               b_sign, b_exp, b_man, b_zero, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_zero
    );
endinterface

// File: rtl/mac_mul_stage.sv
// Two-stage pipelined mantissa multiplier: stage 1 multiplies, stage 2 normalizes.
// Valid/ready on both sides; out_ready back-propagates combinationally to in_ready.
module mac_mul_stage #(
    parameter int unsigned width_exp  = 5,
    parameter int unsigned width_man  = 10,
    parameter int unsigned width_pexp = width_exp + 2,
    parameter int unsigned width_pman = 2*width_man + 1
) (
    input logic            clk,
    input logic            rst,
    mac_mul_stage_if.slave bus
);
    localparam int unsigned PW = 2*width_man + 2;

    logic                  w_s2_adv;
    logic                  w_s1_adv;
    logic [PW-1:0]         w_ma;
    logic [PW-1:0]         w_mb;
    logic [width_pexp-1:0] w_esum_ext;

    logic                  r_s1_valid;
    logic                  r_s1_sign;
    logic                  r_s1_zero;
    logic [width_exp:0]    r_s1_esum;
    logic [PW-1:0]         r_s1_prod;

    logic                  w_nxt_sign;
    logic                  w_nxt_zero;
    logic [width_pexp-1:0] w_nxt_exp;
    logic [width_pman-1:0] w_nxt_man;

    logic                  r_s2_valid;
    logic                  r_out_sign;
    logic                  r_out_zero;
    logic [width_pexp-1:0] r_out_exp;
    logic [width_pman-1:0] r_out_man;

    assign w_s2_adv = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;

    // Hidden leading one restored before the multiply
    assign w_ma = {{(width_man+1){1'b0}}, 1'b1, bus.a_man};
    assign w_mb = {{(width_man+1){1'b0}}, 1'b1, bus.b_man};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_esum  <= '0;
            r_s1_prod  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sign  <= bus.a_sign ^ bus.b_sign;
            r_s1_zero  <= bus.a_zero | bus.b_zero;
            r_s1_esum  <= {1'b0, bus.a_exp} + {1'b0, bus.b_exp};
            r_s1_prod  <= w_ma * w_mb;
        end
    end

    assign w_esum_ext = {{(width_pexp-width_exp-1){1'b0}}, r_s1_esum};

    // Product of two [1,2) values lies in [1,4): at most one position of shift
    always_comb begin
        w_nxt_sign = r_s1_sign;
        w_nxt_zero = 1'b0;
        w_nxt_exp  = w_esum_ext;
        w_nxt_man  = {r_s1_prod[PW-3:0], 1'b0};
        if (r_s1_prod[PW-1]) begin
            w_nxt_exp = w_esum_ext + width_pexp'(1);
            w_nxt_man = r_s1_prod[PW-2:0];
        end
        if (r_s1_zero) begin
            w_nxt_sign = 1'b0;
            w_nxt_zero = 1'b1;
            w_nxt_exp  = '0;
            w_nxt_man  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_sign <= 1'b0;
            r_out_zero <= 1'b0;
            r_out_exp  <= '0;
            r_out_man  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_out_sign <= w_nxt_sign;
            r_out_zero <= w_nxt_zero;
            r_out_exp  <= w_nxt_exp;
            r_out_man  <= w_nxt_man;
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_sign  = r_out_sign;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_exp   = r_out_exp;
    assign bus.out_man   = r_out_man;
endmodule

// File: tb/tb_mac_mul_stage.sv
// Bench for mac_mul_stage: directed scenarios plus a randomized stream scored against
// an arithmetic model of the floating-point product.
module tb_mac_mul_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_mul_stage_if #(.width_exp(5), .width_man(10)) bus ();
    mac_mul_stage #(.width_exp(5), .width_man(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Result word layout: {zero, sign, exp[6:0], man[20:0]}
    logic [29:0] q[$];
    logic        s_in_xfer, s_out_xfer, s_in_ready, s_out_valid, s_have_exp;
    logic [29:0] s_out_word, s_expected;

    function automatic logic [29:0] model(input logic as, input logic [4:0] ae, input logic [9:0] am,
                                          input logic az, input logic bs, input logic [4:0] be,
                                          input logic [9:0] bm, input logic bz);
        int unsigned p, e;
        logic [20:0] m;
        if (az || bz) return {1'b1, 29'd0};
        p = (1024 + int'(am)) * (1024 + int'(bm));
        e = int'(ae) + int'(be);
        if (p >= (1 << 21)) begin
            e = e + 1;
            m = 21'(p - (1 << 21));
        end else begin
            m = 21'((p - (1 << 20)) * 2);
        end
        return {1'b0, as ^ bs, 7'(e), m};
    endfunction

    // One clock: sample at the falling edge, keep the scoreboard, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_out_word  = {bus.out_zero, bus.out_sign, bus.out_exp, bus.out_man};
        s_in_xfer   = !rst && bus.in_valid && bus.in_ready;
        s_out_xfer  = !rst && bus.out_valid && bus.out_ready;
        s_have_exp  = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (s_out_xfer && q.size() > 0) begin
                s_expected = q.pop_front();
                s_have_exp = 1'b1;
            end
            if (s_in_xfer)
                q.push_back(model(bus.a_sign, bus.a_exp, bus.a_man, bus.a_zero,
                                  bus.b_sign, bus.b_exp, bus.b_man, bus.b_zero));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic as, input logic [4:0] ae, input logic [9:0] am, input logic az,
                            input logic bs, input logic [4:0] be, input logic [9:0] bm, input logic bz);
        bus.a_sign = as; bus.a_exp = ae; bus.a_man = am; bus.a_zero = az;
        bus.b_sign = bs; bus.b_exp = be; bus.b_man = bm; bus.b_zero = bz;
    endtask

    task automatic rand_pair(input logic allow_zero);
        set_pair(1'($urandom), 5'($urandom), 10'($urandom), allow_zero && ($urandom_range(0, 7) == 0),
                 1'($urandom), 5'($urandom), 10'($urandom), allow_zero && ($urandom_range(0, 7) == 0));
    endtask

    // Sends the currently driven pair alone through an idle pipe; reports latency and the product
    task automatic send_one(output int lat, output logic [29:0] word, output logic [29:0] expw,
                            output logic got);
        lat = -1; word = '0; expw = '0; got = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (s_in_xfer) break;
        end
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (s_out_xfer) begin
                lat = k; word = s_out_word; expw = s_expected; got = s_have_exp;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        rand_pair(1'b0);
        tick();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        n_checks++;
        if ({bus.out_zero, bus.out_sign, bus.out_exp, bus.out_man} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_out_data got=%h exp=0",
                     {bus.out_zero, bus.out_sign, bus.out_exp, bus.out_man});
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        n_checks++;
        if (s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (s_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_output cycle=%0d got=%b exp=0", i, s_out_valid);
            end
        end
    endtask

    task automatic test_unit();
        int lat; logic [29:0] w, e; logic got;
        set_pair(1'b0, 5'd15, 10'd0, 1'b0, 1'b0, 5'd15, 10'd0, 1'b0);
        send_one(lat, w, e, got);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL unit_latency got=%0d exp=2", lat); end
        n_checks++;
        if (w !== {1'b0, 1'b0, 7'd30, 21'h0}) begin
            n_fail++; $display("FAIL unit_product got=%h exp=%h", w, {1'b0, 1'b0, 7'd30, 21'h0});
        end
        n_checks++;
        if (!got || w !== e) begin n_fail++; $display("FAIL unit_model got=%h exp=%h", w, e); end
    endtask

    task automatic test_normalize();
        int lat; logic [29:0] w, e; logic got;
        set_pair(1'b1, 5'd15, 10'h200, 1'b0, 1'b0, 5'd15, 10'h200, 1'b0);
        send_one(lat, w, e, got);
        n_checks++;
        if (w !== {1'b0, 1'b1, 7'd31, 21'h040000}) begin
            n_fail++; $display("FAIL normalize_product got=%h exp=%h", w, {1'b0, 1'b1, 7'd31, 21'h040000});
        end
        n_checks++;
        if (!got || w !== e) begin n_fail++; $display("FAIL normalize_model got=%h exp=%h", w, e); end
    endtask

    task automatic test_zero();
        int lat; logic [29:0] w, e; logic got;
        set_pair(1'b0, 5'd15, 10'h200, 1'b1, 1'b1, 5'd15, 10'd0, 1'b0);
        send_one(lat, w, e, got);
        n_checks++;
        if (w !== {1'b1, 29'd0}) begin
            n_fail++; $display("FAIL zero_override got=%h exp=%h", w, {1'b1, 29'd0});
        end
    endtask

    task automatic test_backpressure();
        int sent = 0, recv = 0, sent_at_drop = -1, held_cnt = 0;
        logic [29:0] held;
        logic have_held = 1'b0;
        for (int t = 0; t < 40 && recv < 4; t++) begin
            bus.out_ready = !(t >= 2 && t <= 5);
            bus.in_valid  = (sent < 4);
            set_pair(sent[0], 5'(3 + 4*sent), 10'(37*sent + 5), 1'b0,
                     1'b1, 5'(20 - sent), 10'(1000 - 91*sent), 1'b0);
            tick();
            if (bus.in_valid && !s_in_ready && sent_at_drop < 0) sent_at_drop = sent;
            if (s_out_valid && !bus.out_ready) begin
                if (!have_held) begin
                    held = s_out_word; have_held = 1'b1;
                end else begin
                    held_cnt++;
                    n_checks++;
                    if (s_out_word !== held) begin
                        n_fail++; $display("FAIL bp_hold got=%h exp=%h", s_out_word, held);
                    end
                end
            end
            if (s_out_xfer) begin
                recv++;
                n_checks++;
                if (!s_have_exp || s_out_word !== s_expected) begin
                    n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", recv - 1, s_out_word, s_expected);
                end
            end
            if (s_in_xfer) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (sent_at_drop !== 2) begin
            n_fail++; $display("FAIL bp_ready_drop got=%0d exp=2", sent_at_drop);
        end
        n_checks++;
        if (recv !== 4 || q.size() !== 0) begin
            n_fail++; $display("FAIL bp_count got=%0d exp=4 leftover=%0d", recv, q.size());
        end
        n_checks++;
        if (held_cnt < 3) begin n_fail++; $display("FAIL bp_stall_seen got=%0d exp>=3", held_cnt); end
    endtask

    task automatic test_reset_midstream();
        logic full = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int t = 0; t < 10 && !full; t++) begin
            rand_pair(1'b0);
            tick();
            full = s_out_valid && !s_in_ready;
        end
        n_checks++;
        if (!full) begin n_fail++; $display("FAIL mid_fill got=0 exp=1"); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", bus.out_valid);
        end
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (s_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_stale cycle=%0d got=%b exp=0", i, s_out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic prev_stall = 1'b0;
        logic [29:0] prev_word = '0;
        for (int t = 0; t < 400; t++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            rand_pair(1'b1);
            tick();
            if (prev_stall) begin
                n_checks++;
                if (s_out_valid !== 1'b1 || s_out_word !== prev_word) begin
                    n_fail++; $display("FAIL rand_hold t=%0d got=%h exp=%h", t, s_out_word, prev_word);
                end
            end
            if (s_out_xfer) begin
                n_checks++;
                if (!s_have_exp || s_out_word !== s_expected) begin
                    n_fail++; $display("FAIL rand_product t=%0d got=%h exp=%h", t, s_out_word, s_expected);
                end
            end
            prev_stall = s_out_valid && !bus.out_ready;
            prev_word  = s_out_word;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            tick();
            if (s_out_xfer) begin
                n_checks++;
                if (!s_have_exp || s_out_word !== s_expected) begin
                    n_fail++; $display("FAIL rand_drain got=%h exp=%h", s_out_word, s_expected);
                end
            end
        end
        n_checks++;
        if (q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_pair(1'b0, 5'd0, 10'd0, 1'b0, 1'b0, 5'd0, 10'd0, 1'b0);
        test_reset();
        test_unit();
        test_normalize();
        test_zero();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mac_mul_stage.md
Name: mac_mul_stage

Overview:
- Two-stage pipelined multiplier directly downstream of the input unpack stage.
- Consumes two unpacked operands, activation (A) and weight (B), each given as sign, biased exponent, stored mantissa and zero flag.
- Produces a normalized product with raw exponent sum, sign and zero flag for the following accumulate stage.
- Uses a valid/ready handshake on both sides, so backpressure from the accumulator stalls the pipe without loss.

Parameters:
- width_exp, 5, exponent width of each operand.
- width_man, 10, stored mantissa width of each operand; hidden leading one is implicit.
- width_pexp, width_exp+2, product exponent width.
- width_pman, 2*width_man+1, product mantissa (fraction) width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept operand pair this cycle.
- a_sign  in  1  sign of A.
- a_exp  in  width_exp  biased exponent of A.
- a_man  in  width_man  stored mantissa of A.
- a_zero  in  1  A is zero.
- b_sign  in  1  sign of B.
- b_exp  in  width_exp  biased exponent of B.
- b_man  in  width_man  stored mantissa of B.
- b_zero  in  1  B is zero.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_sign  out  1  product sign.
- out_exp  out  width_pexp  a_exp+b_exp+norm, with no bias removed.
- out_man  out  width_pman  normalized product fraction, hidden one dropped.
- out_zero  out  1  product is zero.

Behaviour:
- Reset is synchronous and active-high. One clock. All state is cleared on a rising edge with rst=1, with priority over every other event:
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_sign=0, out_exp=0, out_man=0, out_zero=0.
  - Any data in flight is discarded.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Handshake control:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready.
  - No combinational path exists from in_valid to out_valid.
- Stage 1, loaded on s1_adv:
  - s1_valid <= in_valid.
  - Register the sign as a_sign^b_sign.
  - Register the exponent sum as a_exp+b_exp, zero-extended to width_exp+1.
  - Register z = a_zero|b_zero.
  - Register P = {1,a_man} * {1,b_man}, unsigned, 2*width_man+2 bits.
- Stage 2, loaded on s2_adv, takes s2_valid <= s1_valid and normalizes:
  - If P[MSB]=1: out_exp = esum+1 and out_man = P[MSB-1:0].
  - Else: out_exp = esum and out_man = {P[MSB-2:0],1'b0}.
  - If z=1: out_zero=1 and out_sign=out_exp=out_man=0, overriding all arithmetic.
- Output registers hold their value while out_valid & ~out_ready. Nothing changes until the transfer.
- Latency is 2 cycles from input transfer to out_valid when there are no stalls. Throughput is 1 per cycle with out_ready held high.
- When s1_adv is high with in_valid=0, a bubble enters stage 1. Output data registers are allowed to update during bubbles; only out_valid qualifies them.
- Exponent does not overflow: the maximum is 2*(2^width_exp-1)+1, which fits in width_pexp. There is no saturation and no rounding; the full fraction is kept.
- Full-stall boundary: when both stages hold data and out_ready=0, in_ready=0 and the input is ignored.
- Simultaneous out_ready and in_valid on a full pipe: both stages shift and the new pair is accepted in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles while in_valid=1 with arbitrary data -> out_valid=0, all outputs 0, in_ready=1 the cycle after rst falls.
- Unit product: A=B=1.0 (exp=15, man=0, signs 0), out_ready=1 -> two cycles later out_valid=1, out_exp=30, out_man=0, out_sign=0, out_zero=0.
- Normalize path: A=B=1.5 (exp=15, man=0x200), a_sign=1 -> out_exp=31, out_man=0x040000, out_sign=1.
- Zero override: a_zero=1, A=1.5, B=-1.0 -> out_zero=1, out_sign=0, out_exp=0, out_man=0.
- Backpressure: stream 4 distinct pairs back-to-back with out_ready=0 for cycles 2..5 -> in_ready drops after 2 pairs are held, output holds pair 0 stable, and after release all 4 products emerge in order with none lost or duplicated.
- Reset mid-stream: assert rst while s1 and s2 are both valid -> next cycle out_valid=0, and no stale product appears after reset is released.
